calc_mem_ctrl: RTL
==================

CALC_MEM_CTRL -- requirements
Module: calc_mem_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data width of stored operands/results.
REQ-002 Parameter DEPTH, default 4: number of memory slots; power of two, minimum 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 Escolha  input  4  operation code, sampled on command acceptance.
REQ-007 cmd_valid  input  1  command present.
REQ-008 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-009 din  input  WIDTH  value to save, sampled on acceptance.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer takes response.
REQ-012 rsp_data  output  WIDTH  saved or recalled value.
REQ-013 rsp_err  output  1  recall attempted on empty memory.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-015 Acceptance SHALL occur on a rising edge with cmd_valid=1 and cmd_ready=1; Escolha and din SHALL be latched then.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on acceptance, EXEC->RESP unconditionally, RESP->IDLE on rsp_ready=1.
REQ-017 Codes SHALL be: 4'b1111 SAVE, 4'b1110 RECALL_LAST, 4'b1010 RECALL_OLDEST, 4'b0000 CLEAR; all others NOP.
REQ-018 SAVE in EXEC SHALL write mem[wr_ptr]<=din, wr_ptr<=wr_ptr+1 mod DEPTH, count<=min(count+1, DEPTH).
REQ-019 SAVE with count=DEPTH SHALL overwrite the oldest entry; count stays DEPTH.
REQ-020 RECALL_LAST SHALL return mem[(wr_ptr-1) mod DEPTH]; RECALL_OLDEST SHALL return mem[(wr_ptr-count) mod DEPTH]; pointers and count unchanged.
REQ-021 Recall with count=0 SHALL respond rsp_data=0, rsp_err=1.
REQ-022 SAVE response SHALL carry rsp_data=din latched, rsp_err=0.
REQ-023 CLEAR SHALL set count=0, wr_ptr=0, leave memory contents unchanged, respond rsp_data=0, rsp_err=0.
REQ-024 NOP SHALL change no state and respond rsp_data=0, rsp_err=0.
REQ-025 rsp_valid SHALL rise exactly 2 cycles after the acceptance edge and hold, with rsp_data/rsp_err stable, until the edge where rsp_ready=1.
REQ-026 rsp_ready while rsp_valid=0 SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (no queuing).
REQ-027 Next command SHALL be acceptable no earlier than the cycle after the response handshake (throughput 1 command / 3 cycles minimum).
REQ-028 count SHALL update at the EXEC edge, visible when rsp_valid rises.

Reset
REQ-029 rst_n=0 SHALL force state IDLE, wr_ptr=0, count=0, rsp_valid=0, rsp_data=0, rsp_err=0 immediately, regardless of clk.
REQ-030 cmd_ready SHALL be 1 during and after reset (IDLE).
REQ-031 Reset mid-operation SHALL abandon the in-flight command with no response; memory contents need not be reset.

Verification
REQ-032 Reset, RECALL_LAST -> rsp_data=0, rsp_err=1, count=0, rsp_valid 2 cycles after acceptance.
REQ-033 SAVE 0x0011, 0x0022, 0x0033, then RECALL_LAST -> 0x0033; RECALL_OLDEST -> 0x0011; count=3.
REQ-034 DEPTH=4: SAVE 1..5 -> count=4; RECALL_OLDEST -> 2; RECALL_LAST -> 5.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, cmd_valid pulses ignored.
REQ-036 CLEAR after 2 saves -> count=0; RECALL_OLDEST -> rsp_err=1; Escolha=4'b0101 -> count unchanged, rsp_data=0.
REQ-037 Assert rst_n=0 while in EXEC of a SAVE -> rsp_valid=0, count=0, cmd_ready=1 without clock edge.

Source files
------------

// File: rtl/calc_mem_ctrl.sv
// calc_mem_ctrl: command-driven save/recall controller over a small circular
// history buffer. Each command runs IDLE -> EXEC -> RESP, one command in flight.
module calc_mem_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               Escolha,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         din,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] OpSave         = 4'b1111;
  localparam logic [3:0] OpRecallLast   = 4'b1110;
  localparam logic [3:0] OpRecallOldest = 4'b1010;
  localparam logic [3:0] OpClear        = 4'b0000;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_we;
  logic [PtrW-1:0]   last_idx, oldest_idx;

  logic [WIDTH-1:0]  mem [DEPTH];

  // Newest entry sits just behind the write pointer; the oldest is count slots
  // behind it. With a full buffer the count's low bits are zero, so the oldest
  // index lands on the write pointer, which is the slot about to be overwritten.
  assign last_idx   = wr_ptr_q - PtrW'(1);
  assign oldest_idx = wr_ptr_q - count_q[PtrW-1:0];

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;

  // Next-state: latch on acceptance, execute the operation in EXEC, hold in RESP.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    din_d      = din_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = Escolha;
          din_d   = din;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d    = StResp;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        case (op_q)
          OpSave: begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PtrW'(1);
            rsp_data_d = din_q;
            if (count_q != CntW'(DEPTH)) count_d = count_q + CntW'(1);
          end
          OpRecallLast: begin
            if (count_q == '0) rsp_err_d = 1'b1;
            else               rsp_data_d = mem[last_idx];
          end
          OpRecallOldest: begin
            if (count_q == '0) rsp_err_d = 1'b1;
            else               rsp_data_d = mem[oldest_idx];
          end
          OpClear: begin
            count_d  = '0;
            wr_ptr_d = '0;
          end
          default: ;
        endcase
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      din_q      <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      din_q      <= din_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage array: contents survive reset and CLEAR.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= din_q;
  end

endmodule
